// File: rtl/stg_fq.sv
// rtl/stg_fq.sv - 4-entry fetch queue with registered output stage feeding the translate stage

`ifndef HBIT_ADDR
`define HBIT_ADDR 15
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef OPC_NOP
`define OPC_NOP 8'h00
`endif
`ifndef OPC_JCCui
`define OPC_JCCui 8'h2c
`endif

module stg_fq (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic                iw_valid,
  input  logic [`HBIT_ADDR:0] iw_pc,
  input  logic [`HBIT_DATA:0] iw_instr,
  output logic                ow_ready,
  input  logic                iw_stall,
  input  logic                iw_flush,
  output logic                ow_valid,
  output logic [`HBIT_ADDR:0] ow_pc,
  output logic [`HBIT_DATA:0] ow_instr,
  output logic [2:0]          ow_count
);

  // Bubble presented whenever no real word is available.
  localparam logic [`HBIT_DATA:0] NOP_WORD = {`OPC_NOP, 16'b0};

  // Entry storage; contents are never cleared, only pointers and count are.
  logic [`HBIT_ADDR:0] pc_mem    [4];
  logic [`HBIT_DATA:0] instr_mem [4];

  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;

  logic push_en;
  logic pop_en;

  // Ready looks only at the registered count, so a pop never frees a slot
  // for a push on the same edge.
  assign ow_ready = (count_q < 3'd4);
  assign ow_count = count_q;

  // Push/pop qualification; flush overrides both.
  always_comb begin
    push_en = iw_valid & ow_ready & ~iw_flush;
    pop_en  = ~iw_stall & ~iw_flush & (count_q != 3'd0);
  end

  // Entry write at the tail on an accepted push.
  always_ff @(posedge iw_clk) begin
    if (push_en) begin
      pc_mem[wr_ptr_q]    <= iw_pc;
      instr_mem[wr_ptr_q] <= iw_instr;
    end
  end

  // Pointer and occupancy bookkeeping; 2-bit pointers wrap 3->0 naturally.
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else if (iw_flush) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Output register: load head on advance, bubble when empty, hold on stall.
  // The PC is deliberately left alone on bubbles so the last address stays visible.
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      ow_valid <= 1'b0;
      ow_pc    <= '0;
      ow_instr <= NOP_WORD;
    end else if (iw_flush) begin
      ow_valid <= 1'b0;
      ow_instr <= NOP_WORD;
    end else if (!iw_stall) begin
      if (count_q != 3'd0) begin
        ow_valid <= 1'b1;
        ow_pc    <= pc_mem[rd_ptr_q];
        ow_instr <= instr_mem[rd_ptr_q];
      end else begin
        ow_valid <= 1'b0;
        ow_instr <= NOP_WORD;
      end
    end
  end

endmodule

// File: tb/tb_stg_fq.sv
// tb/tb_stg_fq.sv - self-checking bench for stg_fq with queue-based reference model

`ifndef HBIT_ADDR
`define HBIT_ADDR 15
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef OPC_NOP
`define OPC_NOP 8'h00
`endif
`ifndef OPC_JCCui
`define OPC_JCCui 8'h2c
`endif

module tb_stg_fq;

  localparam int AW = `HBIT_ADDR + 1;
  localparam int DW = `HBIT_DATA + 1;
  localparam logic [DW-1:0] NOP_W = {`OPC_NOP, 16'b0};

  logic          clk;
  logic          rst;
  logic          valid;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr;
  logic          stall;
  logic          flush;
  logic          o_ready;
  logic          o_valid;
  logic [AW-1:0] o_pc;
  logic [DW-1:0] o_instr;
  logic [2:0]    o_count;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: a queue of {pc,instr} plus the presented word
  logic [AW+DW-1:0] mq[$];
  logic             m_valid;
  logic [AW-1:0]    m_pc;
  logic [DW-1:0]    m_instr;

  stg_fq dut (
    .iw_clk   (clk),
    .iw_rst   (rst),
    .iw_valid (valid),
    .iw_pc    (pc),
    .iw_instr (instr),
    .ow_ready (o_ready),
    .iw_stall (stall),
    .iw_flush (flush),
    .ow_valid (o_valid),
    .ow_pc    (o_pc),
    .ow_instr (o_instr),
    .ow_count (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_pc    = '0;
    m_instr = NOP_W;
  endtask

  // one clock edge: apply inputs, advance model, then settle 1 time unit past the edge
  task automatic tick(input logic v, input logic [AW-1:0] p, input logic [DW-1:0] ins,
                      input logic s, input logic f);
    logic [AW+DW-1:0] head;
    bit take;
    valid = v; pc = p; instr = ins; stall = s; flush = f;
    @(posedge clk);
    if (f) begin
      mq.delete();
      m_valid = 1'b0;
      m_instr = NOP_W;
    end else begin
      take = v && (mq.size() < 4);
      if (!s) begin
        if (mq.size() > 0) begin
          head    = mq.pop_front();
          m_pc    = head[AW+DW-1:DW];
          m_instr = head[DW-1:0];
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
          m_instr = NOP_W;
        end
      end
      if (take) mq.push_back({p, ins});
    end
    #1;
  endtask

  task automatic idle(input logic s);
    tick(1'b0, '0, '0, s, 1'b0);
  endtask

  task automatic do_reset();
    valid = 0; pc = '0; instr = '0; stall = 0; flush = 0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; valid = 0; pc = '0; instr = '0; stall = 0; flush = 0;
    #2;
    n_checks++;
    if ({o_valid, o_pc, o_instr, o_ready, o_count} !== {1'b0, {AW{1'b0}}, NOP_W, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_held: got v=%0b pc=%h ins=%h rdy=%0b cnt=%0d want v=0 pc=0 ins=%h rdy=1 cnt=0",
               o_valid, o_pc, o_instr, o_ready, o_count, NOP_W);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    idle(1'b0);
    n_checks++;
    if ({o_valid, o_pc, o_instr, o_ready, o_count} !== {1'b0, {AW{1'b0}}, NOP_W, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_release: got v=%0b pc=%h ins=%h rdy=%0b cnt=%0d want v=0 pc=0 ins=%h rdy=1 cnt=0",
               o_valid, o_pc, o_instr, o_ready, o_count, NOP_W);
    end
  endtask

  task automatic test_single_word();
    logic [DW-1:0] w;
    w = {`OPC_JCCui, 4'b1010, 12'h123};
    do_reset();
    tick(1'b1, 16'h0010, w, 1'b0, 1'b0);
    n_checks++;
    if (o_count !== 3'd1) begin
      n_fail++; $display("FAIL single_count1: got %0d want 1", o_count);
    end
    idle(1'b0);
    n_checks++;
    if ({o_valid, o_pc, o_instr, o_count} !== {1'b1, 16'h0010, w, 3'd0}) begin
      n_fail++;
      $display("FAIL single_present: got v=%0b pc=%h ins=%h cnt=%0d want v=1 pc=0010 ins=%h cnt=0",
               o_valid, o_pc, o_instr, o_count, w);
    end
    idle(1'b0);
    n_checks++;
    if ({o_valid, o_pc, o_instr} !== {1'b0, 16'h0010, NOP_W}) begin
      n_fail++;
      $display("FAIL single_bubble: got v=%0b pc=%h ins=%h want v=0 pc=0010 ins=%h",
               o_valid, o_pc, o_instr, NOP_W);
    end
  endtask

  task automatic test_fill_stall();
    logic [AW-1:0] exp_pc;
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, AW'(16'h20 + i), DW'(32'h00a000 + i), 1'b1, 1'b0);
    n_checks++;
    if ({o_count, o_ready} !== {3'd4, 1'b0}) begin
      n_fail++; $display("FAIL fill_full: got cnt=%0d rdy=%0b want cnt=4 rdy=0", o_count, o_ready);
    end
    tick(1'b1, 16'h0024, 24'h00a004, 1'b1, 1'b0);
    n_checks++;
    if ({o_count, o_valid} !== {3'd4, 1'b0}) begin
      n_fail++; $display("FAIL fill_reject: got cnt=%0d v=%0b want cnt=4 v=0", o_count, o_valid);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      exp_pc = AW'(16'h20 + i);
      n_checks++;
      if ({o_valid, o_pc, o_instr} !== {1'b1, exp_pc, DW'(32'h00a000 + i)}) begin
        n_fail++;
        $display("FAIL fill_drain%0d: got v=%0b pc=%h ins=%h want v=1 pc=%h", i, o_valid, o_pc, o_instr, exp_pc);
      end
    end
    idle(1'b0);
    n_checks++;
    if ({o_valid, o_pc, o_instr, o_count} !== {1'b0, 16'h0023, NOP_W, 3'd0}) begin
      n_fail++;
      $display("FAIL fill_empty: got v=%0b pc=%h ins=%h cnt=%0d want v=0 pc=0023 NOP cnt=0",
               o_valid, o_pc, o_instr, o_count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, AW'(16'h50 + i), DW'(32'h00b000 + i), 1'b1, 1'b0);
    n_checks++;
    if (o_count !== 3'd3) begin
      n_fail++; $display("FAIL flush_pre: got cnt=%0d want 3", o_count);
    end
    tick(1'b1, 16'h0030, 24'h00c030, 1'b1, 1'b1);
    n_checks++;
    if ({o_count, o_valid, o_instr, o_ready} !== {3'd0, 1'b0, NOP_W, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_edge: got cnt=%0d v=%0b ins=%h rdy=%0b want cnt=0 v=0 NOP rdy=1",
               o_count, o_valid, o_instr, o_ready);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      n_checks++;
      if (o_valid !== 1'b0 || o_pc === 16'h0030) begin
        n_fail++; $display("FAIL flush_ghost%0d: got v=%0b pc=%h want v=0 and pc!=0030", i, o_valid, o_pc);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(1'b1, 16'h0060, 24'h00d060, 1'b1, 1'b0);
    tick(1'b1, 16'h0061, 24'h00d061, 1'b1, 1'b0);
    tick(1'b1, 16'h0040, 24'h00d040, 1'b0, 1'b0);
    n_checks++;
    if ({o_count, o_valid, o_pc} !== {3'd2, 1'b1, 16'h0060}) begin
      n_fail++;
      $display("FAIL pushpop: got cnt=%0d v=%0b pc=%h want cnt=2 v=1 pc=0060", o_count, o_valid, o_pc);
    end
    idle(1'b0);
    n_checks++;
    if (o_pc !== 16'h0061) begin
      n_fail++; $display("FAIL pushpop_second: got pc=%h want 0061", o_pc);
    end
    idle(1'b0);
    n_checks++;
    if ({o_valid, o_pc, o_instr} !== {1'b1, 16'h0040, 24'h00d040}) begin
      n_fail++; $display("FAIL pushpop_third: got v=%0b pc=%h ins=%h want v=1 pc=0040 ins=00d040",
                         o_valid, o_pc, o_instr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, AW'(16'h70 + i), DW'(32'h00e000 + i), 1'b1, 1'b0);
    idle(1'b0);
    n_checks++;
    if ({o_count, o_valid} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL async_pre: got cnt=%0d v=%0b want cnt=3 v=1", o_count, o_valid);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, o_pc, o_instr, o_ready, o_count} !== {1'b0, {AW{1'b0}}, NOP_W, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%0b pc=%h ins=%h rdy=%0b cnt=%0d want reset values",
               o_valid, o_pc, o_instr, o_ready, o_count);
    end
    #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    tick(1'b1, 16'h0080, 24'h00e080, 1'b0, 1'b0);
    idle(1'b0);
    n_checks++;
    if ({o_valid, o_pc} !== {1'b1, 16'h0080}) begin
      n_fail++; $display("FAIL async_resume: got v=%0b pc=%h want v=1 pc=0080", o_valid, o_pc);
    end
  endtask

  task automatic test_random();
    logic v, s, f;
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(99) < 70);
      s = ($urandom_range(99) < 35);
      f = ($urandom_range(99) < 4);
      tick(v, AW'($urandom), DW'($urandom), s, f);
      n_checks++;
      if ({o_valid, o_pc, o_instr, o_count, o_ready} !==
          {m_valid, m_pc, m_instr, 3'(mq.size()), (mq.size() < 4)}) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random_cyc%0d: got v=%0b pc=%h ins=%h cnt=%0d rdy=%0b want v=%0b pc=%h ins=%h cnt=%0d rdy=%0b",
                   i, o_valid, o_pc, o_instr, o_count, o_ready,
                   m_valid, m_pc, m_instr, mq.size(), (mq.size() < 4));
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
